// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the UART loopback PLL, clocked by the PLL reference clock.
// Optional feature: define PLL_SEQ_AUTO_RELOCK_EN to re-run the sequence after a lock loss instead of faulting.
module pll_lock_sequencer #(
   parameter int unsigned RST_HOLD_CYC     = 250,
   parameter int unsigned LOCK_TIMEOUT_CYC = 25000,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned MAX_RETRY        = 3
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic       pll_extlock,
   input  logic       restart,
   output logic       pll_reset,
   output logic       sys_rst,
   output logic       locked,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      RST_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } state_t;

   localparam logic [23:0] HOLD_LAST    = 24'(RST_HOLD_CYC - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE_CYC - 1);
   localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

   state_t      state, state_next;
   logic [23:0] cnt, cnt_next;
   logic [3:0]  retry_next;
   logic [7:0]  loss_next;
   logic        sync_meta, lock_s;

   // pll_extlock comes from the PLL's own clocking, so it is resynchronized before use.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make both flops sample the old values, forming a true 2-stage chain.
         sync_meta <= pll_extlock;
         lock_s    <= sync_meta;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_next = state;
      retry_next = retry_cnt;
      loss_next  = loss_cnt;
      if (restart) begin
         state_next = RST_PLL;
         retry_next = 4'd0;
      end else begin
         case (state)
            RST_PLL: begin
               if (cnt == HOLD_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_next = STABLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  if (retry_cnt == RETRY_LIMIT) begin
                     state_next = FAULT;
                  end else begin
                     retry_next = retry_cnt + 4'd1;
                     state_next = RST_PLL;
                  end
               end
            end
            STABLE: begin
               if (!lock_s)                 state_next = WAIT_LOCK;
               else if (cnt == STABLE_LAST) state_next = RUN;
            end
            RUN: begin
               if (!lock_s) begin
                  if (loss_cnt != 8'hFF) loss_next = loss_cnt + 8'd1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                  state_next = RST_PLL;
                  retry_next = 4'd0;
`else
                  state_next = FAULT;
`endif
               end
            end
            FAULT:   state_next = FAULT;
            default: state_next = RST_PLL;
         endcase
      end
      // A restart re-enters RST_PLL from RST_PLL too, so it must clear the counter explicitly.
      cnt_next = (restart || (state_next != state)) ? 24'd0 : cnt + 24'd1;
   end

   // Outputs are decoded from the next state so they move on the same edge as the transition.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state     <= RST_PLL;
         cnt       <= 24'd0;
         retry_cnt <= 4'd0;
         loss_cnt  <= 8'd0;
         pll_reset <= 1'b1;
         sys_rst   <= 1'b1;
         locked    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         retry_cnt <= retry_next;
         loss_cnt  <= loss_next;
         pll_reset <= (state_next == RST_PLL) || (state_next == FAULT);
         sys_rst   <= (state_next != RUN);
         locked    <= (state_next == RUN);
         fault     <= (state_next == FAULT);
      end
   end

endmodule
